// File: rtl/tone_voice_if.sv
// tone_voice_if: request/sample bus between the I2S frame logic and tone_voice.
//   master: drives key_on, key_note, sample_req; observes sample outputs/status.
//   slave : tone_voice side.
interface tone_voice_if;
    logic        key_on;
    logic [3:0]  key_note;
    logic        sample_req;
    logic        sample_valid;
    logic [15:0] sample;
    logic [9:0]  tone_half_period;
    logic [1:0]  env_state;
    logic        req_overrun;

    modport master (
        output key_on, key_note, sample_req,
        input  sample_valid, sample, tone_half_period, env_state, req_overrun
    );

    modport slave (
        input  key_on, key_note, sample_req,
        output sample_valid, sample, tone_half_period, env_state, req_overrun
    );
endinterface

// File: rtl/tone_voice.sv
// tone_voice: one square-wave voice with an attack/release amplitude envelope,
// producing one signed 16-bit sample per I2S frame on request.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - tone_voice_if.slave:
//          key_on/key_note (in), sample_req strobe (in),
//          sample_valid strobe / sample (out), tone_half_period (out),
//          env_state 0 IDLE 1 ATTACK 2 SUSTAIN 3 RELEASE (out),
//          req_overrun sticky flag (out)
// Timing: request sampled at edge E updates envelope/phase at E; the sample
// appears with sample_valid at E+1. Requests at E+1 and E+2 are dropped.
module tone_voice #(
    parameter logic [15:0] ATTACK_STEP  = 16'd256,
    parameter logic [15:0] RELEASE_STEP = 16'd128,
    parameter logic [15:0] AMP_MAX      = 16'h7FFF
) (
    input logic         clk,
    input logic         rst,
    tone_voice_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_t;

    env_t        state_q, state_d;
    logic [15:0] amp_q, amp_d;
    logic [9:0]  phase_q, phase_d;
    logic [9:0]  hp_q, hp_d;
    logic        pol_q, pol_d;
    logic [3:0]  note_q, note_d;
    logic [15:0] sample_q, sample_d;
    logic        pend_q;
    logic        valid_q;
    logic        overrun_q;
    logic        busy;
    logic        accept;
    logic [16:0] amp_up;
    logic [16:0] amp_dn;

    // Half-period in 48 kHz frames for C4..D#5.
    function automatic logic [9:0] note_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    note_lut = 10'd92;
            4'd1:    note_lut = 10'd87;
            4'd2:    note_lut = 10'd82;
            4'd3:    note_lut = 10'd77;
            4'd4:    note_lut = 10'd73;
            4'd5:    note_lut = 10'd69;
            4'd6:    note_lut = 10'd65;
            4'd7:    note_lut = 10'd61;
            4'd8:    note_lut = 10'd58;
            4'd9:    note_lut = 10'd55;
            4'd10:   note_lut = 10'd51;
            4'd11:   note_lut = 10'd49;
            4'd12:   note_lut = 10'd46;
            4'd13:   note_lut = 10'd43;
            4'd14:   note_lut = 10'd41;
            default: note_lut = 10'd39;
        endcase
    endfunction

    always_comb begin
        busy    = pend_q | valid_q;
        accept  = bus.sample_req & ~busy;
        amp_up  = {1'b0, amp_q} + {1'b0, ATTACK_STEP};
        amp_dn  = {1'b0, amp_q} - {1'b0, RELEASE_STEP};

        note_d  = note_q;
        hp_d    = hp_q;
        phase_d = phase_q;
        pol_d   = pol_q;
        if (bus.key_on && (state_q == ST_IDLE || state_q == ST_RELEASE || bus.key_note != note_q)) begin
            note_d  = bus.key_note;
            hp_d    = note_lut(bus.key_note);
            phase_d = '0;
            pol_d   = 1'b1;
        end else if (phase_q == hp_q - 10'd1) begin
            phase_d = '0;
            pol_d   = ~pol_q;
        end else begin
            phase_d = phase_q + 10'd1;
        end

        // The transition and its first amplitude step happen on the same
        // request, so a fresh key yields +ATTACK_STEP on its first sample.
        state_d = state_q;
        amp_d   = amp_q;
        if (bus.key_on) begin
            if (state_q != ST_SUSTAIN) begin
                if (amp_up >= {1'b0, AMP_MAX}) begin
                    amp_d   = AMP_MAX;
                    state_d = ST_SUSTAIN;
                end else begin
                    amp_d   = amp_up[15:0];
                    state_d = ST_ATTACK;
                end
            end
        end else if (state_q != ST_IDLE) begin
            // Borrow out of bit 16 means the step went below zero.
            if (amp_dn[16] || amp_dn[15:0] == 16'd0) begin
                amp_d   = '0;
                state_d = ST_IDLE;
            end else begin
                amp_d   = amp_dn[15:0];
                state_d = ST_RELEASE;
            end
        end

        // Second pipeline stage works from the already-updated registers.
        if (state_q == ST_IDLE) begin
            sample_d = '0;
        end else if (pol_q) begin
            sample_d = amp_q;
        end else begin
            sample_d = ~amp_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            amp_q     <= '0;
            phase_q   <= '0;
            hp_q      <= 10'd92;
            pol_q     <= 1'b1;
            note_q    <= '0;
            sample_q  <= '0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pend_q  <= accept;
            valid_q <= pend_q;
            if (pend_q) begin
                sample_q <= sample_d;
            end
            if (accept) begin
                state_q <= state_d;
                amp_q   <= amp_d;
                phase_q <= phase_d;
                hp_q    <= hp_d;
                pol_q   <= pol_d;
                note_q  <= note_d;
            end
            if (bus.sample_req && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.sample_valid     = valid_q;
    assign bus.sample           = sample_q;
    assign bus.tone_half_period = hp_q;
    assign bus.env_state        = state_q;
    assign bus.req_overrun      = overrun_q;

endmodule
